// File: rtl/cache_param_wb_ctrl_dpath.sv
// Direct-mapped, write-back, write-allocate blocking cache with parametrised geometry.
// Sits between a processor val/rdy port and a main-memory val/rdy port (4B messages).
module cache_param_wb_ctrl_dpath #(
  parameter int NUM_LINES  = 32,
  parameter int LINE_WORDS = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memreq_val,
  output logic        memreq_rdy,
  input  logic [76:0] memreq_msg,
  output logic        memresp_val,
  input  logic        memresp_rdy,
  output logic [46:0] memresp_msg,
  output logic        cache_req_val,
  input  logic        cache_req_rdy,
  output logic [76:0] cache_req_msg,
  input  logic        cache_resp_val,
  output logic        cache_resp_rdy,
  input  logic [46:0] cache_resp_msg
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int TAG_W = 32 - 2 - OFF_W - IDX_W;
  localparam int WADDR_W = IDX_W + OFF_W;

  localparam logic [2:0] TYPE_READ  = 3'd0;
  localparam logic [2:0] TYPE_WRITE = 3'd1;
  localparam logic [2:0] TYPE_INIT  = 3'd2;

  localparam logic [OFF_W-1:0] CNT_LAST = OFF_W'(LINE_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TAG,
    S_EVICT_REQ,
    S_EVICT_WAIT,
    S_REFILL_REQ,
    S_REFILL_WAIT,
    S_RESP
  } state_t;

  state_t               state_reg, state_next;
  logic [OFF_W-1:0]     cnt_reg, cnt_next;
  logic [76:0]          req_reg;
  logic [NUM_LINES-1:0] valid_reg;
  logic [NUM_LINES-1:0] dirty_reg;

  logic [TAG_W-1:0] tag_mem  [NUM_LINES];
  logic [31:0]      data_mem [NUM_LINES*LINE_WORDS];

  // Request register fields
  logic [2:0]       req_type;
  logic [7:0]       req_opaque;
  logic [31:0]      req_addr;
  logic [1:0]       req_len;
  logic [31:0]      req_data;
  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] req_idx;
  logic [OFF_W-1:0] req_off;

  assign req_type   = req_reg[76:74];
  assign req_opaque = req_reg[73:66];
  assign req_addr   = req_reg[65:34];
  assign req_len    = req_reg[33:32];
  assign req_data   = req_reg[31:0];
  assign req_tag    = req_addr[31 -: TAG_W];
  assign req_idx    = req_addr[2+OFF_W +: IDX_W];
  assign req_off    = req_addr[2 +: OFF_W];

  logic [TAG_W-1:0] line_tag;
  logic             line_valid;
  logic             line_dirty;
  logic             hit;

  assign line_tag   = tag_mem[req_idx];
  assign line_valid = valid_reg[req_idx];
  assign line_dirty = dirty_reg[req_idx];
  assign hit        = line_valid && (line_tag == req_tag);

  // Datapath control produced by the FSM
  logic               data_we;
  logic [OFF_W-1:0]   data_woff;
  logic [31:0]        data_wdata;
  logic               tag_we;
  logic               set_valid;
  logic               set_dirty;
  logic               clr_dirty;

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    data_we        = 1'b0;
    data_woff      = req_off;
    data_wdata     = req_data;
    tag_we         = 1'b0;
    set_valid      = 1'b0;
    set_dirty      = 1'b0;
    clr_dirty      = 1'b0;
    memreq_rdy     = 1'b0;
    memresp_val    = 1'b0;
    cache_req_val  = 1'b0;
    cache_resp_rdy = 1'b0;

    case (state_reg)
      S_IDLE: begin
        memreq_rdy = 1'b1;
        if (memreq_val) state_next = S_TAG;
      end
      S_TAG: begin
        if (req_type == TYPE_INIT) begin
          data_we    = 1'b1;
          tag_we     = 1'b1;
          set_valid  = 1'b1;
          clr_dirty  = 1'b1;
          state_next = S_RESP;
        end else if (hit) begin
          if (req_type == TYPE_WRITE) begin
            data_we   = 1'b1;
            set_dirty = 1'b1;
          end
          state_next = S_RESP;
        end else begin
          cnt_next   = '0;
          state_next = (line_valid && line_dirty) ? S_EVICT_REQ : S_REFILL_REQ;
        end
      end
      S_EVICT_REQ: begin
        cache_req_val = 1'b1;
        if (cache_req_rdy) state_next = S_EVICT_WAIT;
      end
      S_EVICT_WAIT: begin
        cache_resp_rdy = 1'b1;
        if (cache_resp_val) begin
          if (cnt_reg == CNT_LAST) begin
            cnt_next   = '0;
            state_next = S_REFILL_REQ;
          end else begin
            cnt_next   = cnt_reg + OFF_W'(1);
            state_next = S_EVICT_REQ;
          end
        end
      end
      S_REFILL_REQ: begin
        cache_req_val = 1'b1;
        if (cache_req_rdy) state_next = S_REFILL_WAIT;
      end
      S_REFILL_WAIT: begin
        cache_resp_rdy = 1'b1;
        if (cache_resp_val) begin
          data_we    = 1'b1;
          data_woff  = cnt_reg;
          data_wdata = cache_resp_msg[31:0];
          if (cnt_reg == CNT_LAST) begin
            tag_we     = 1'b1;
            set_valid  = 1'b1;
            clr_dirty  = 1'b1;
            state_next = S_TAG;
          end else begin
            cnt_next   = cnt_reg + OFF_W'(1);
            state_next = S_REFILL_REQ;
          end
        end
      end
      S_RESP: begin
        memresp_val = 1'b1;
        if (memresp_rdy) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      req_reg   <= '0;
      valid_reg <= '0;
      dirty_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (memreq_val && memreq_rdy) req_reg <= memreq_msg;
      if (set_valid) valid_reg[req_idx] <= 1'b1;
      if (set_dirty) dirty_reg[req_idx] <= 1'b1;
      else if (clr_dirty) dirty_reg[req_idx] <= 1'b0;
    end
  end

  // Tag/data contents need no reset: valid bits gate every use.
  always_ff @(posedge clk) begin
    if (data_we) data_mem[{req_idx, data_woff}] <= data_wdata;
    if (tag_we) tag_mem[req_idx] <= req_tag;
  end

  // Memory-side message: eviction writes the victim word, refill reads the new line.
  logic [WADDR_W-1:0] cnt_waddr;
  logic [WADDR_W-1:0] resp_waddr;
  logic               evicting;
  logic [31:0]        mem_addr;
  logic [31:0]        resp_data;

  assign cnt_waddr  = {req_idx, cnt_reg};
  assign resp_waddr = {req_idx, req_off};
  assign evicting   = (state_reg == S_EVICT_REQ);
  assign mem_addr   = evicting ? {line_tag, req_idx, cnt_reg, 2'b00}
                               : {req_tag, req_idx, cnt_reg, 2'b00};

  assign cache_req_msg = {evicting ? TYPE_WRITE : TYPE_READ,
                          8'(cnt_reg),
                          mem_addr,
                          2'b00,
                          evicting ? data_mem[cnt_waddr] : 32'h0};

  assign resp_data = (req_type == TYPE_WRITE || req_type == TYPE_INIT) ? 32'h0
                                                                      : data_mem[resp_waddr];
  assign memresp_msg = {req_type, req_opaque, 2'b00, req_len, resp_data};

  logic unused_bits;
  assign unused_bits = ^{cache_resp_msg[46:32], req_addr[1:0]};

endmodule
